// File: rtl/ex_alu.sv
// ex_alu: 32-bit execute stage with a single-cycle ALU and an optional iterative mul/div unit.
// Build option: define EX_MULDIV_EN to include the mul/div sequencer; without it, type 4 retires as illegal.
module ex_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_op1,
    input  logic [31:0] alu_op2,
    input  logic        alu_rd_reg_en,
    input  logic [4:0]  alu_rd_reg_addr,
    input  logic [31:0] alu_pc,
    input  logic [31:0] alu_inst,
    input  logic [2:0]  alu_inst_type,
    input  logic        alu_or_flag,
    output logic        ex_stall,
    output logic        ex_valid,
    output logic        ex_wb_en,
    output logic [4:0]  ex_wb_addr,
    output logic [31:0] ex_wb_data,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic        ex_illegal
);
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic [31:0] arith, sra, alu_res, nxt_data;
    logic        illegal, nxt_valid, nxt_ill;

    assign f3  = alu_inst[14:12];
    assign sh  = alu_op2[4:0];
    assign sra = $signed(alu_op1) >>> sh;

    // integer op selected by funct3; SUB only for register-register encodings
    always_comb begin
        case (f3)
            3'd0:    arith = (alu_inst[30] && alu_inst[5]) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
            3'd1:    arith = alu_op1 << sh;
            3'd2:    arith = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            3'd3:    arith = {31'd0, alu_op1 < alu_op2};
            3'd4:    arith = alu_op1 ^ alu_op2;
            3'd5:    arith = alu_inst[30] ? sra : alu_op1 >> sh;
            3'd6:    arith = alu_op1 | alu_op2;
            default: arith = alu_op1 & alu_op2;
        endcase
    end

    assign alu_res = alu_inst_type == 3'd1 ? (alu_or_flag ? alu_op1 | alu_op2 : arith) :
                     alu_inst_type == 3'd2 ? alu_op2 :
                     alu_inst_type == 3'd3 ? alu_pc + 32'd4 : 32'd0;

`ifdef EX_MULDIV_EN
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  md_f3;
    logic [31:0] acc, quo, mag, acc_n, quo_n, div_d, md_res;
    logic [32:0] mul_sum, div_r;
    logic [63:0] prod;
    logic        neg_p, neg_r, div_zero, div_ge, last, s1, s2;

    // operand signedness per RV32M: op1 signed for MUL/MULH/MULHSU/DIV/REM, op2 only for MUL/MULH/DIV/REM
    assign s1 = alu_op1[31] && f3 != 3'd3 && f3 != 3'd5 && f3 != 3'd7;
    assign s2 = alu_op2[31] && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
    assign illegal  = alu_inst_type > 3'd4;
    assign last     = state == BUSY && cnt == 5'd31;
    assign ex_stall = rst_n && (state == BUSY ? !last : alu_inst_type == 3'd4);
    // acc:quo is the product (shift-add) or remainder:quotient (restoring divide) on magnitudes
    assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, mag} : 33'd0);
    assign div_r   = {acc, quo[31]};
    assign div_ge  = div_r >= {1'b0, mag};
    assign div_d   = div_r[31:0] - mag;
    assign acc_n   = md_f3[2] ? (div_ge ? div_d : div_r[31:0]) : mul_sum[32:1];
    assign quo_n   = md_f3[2] ? {quo[30:0], div_ge} : {mul_sum[0], quo[31:1]};
    assign prod    = neg_p ? -{acc_n, quo_n} : {acc_n, quo_n};
    assign md_res  = md_f3 == 3'd0 ? prod[31:0] :
                     !md_f3[2]     ? prod[63:32] :
                     !md_f3[1]     ? (div_zero ? 32'hFFFF_FFFF : neg_p ? -quo_n : quo_n) :
                     neg_r         ? -acc_n : acc_n;
    assign nxt_valid = state == BUSY ? last : alu_inst_type != 3'd0 && alu_inst_type != 3'd4;
    assign nxt_data  = state == BUSY ? md_res : alu_res;
    assign nxt_ill   = state != BUSY && illegal;

    // mul/div sequencer: latch magnitudes and signs in IDLE, then 32 iterations in BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            md_f3    <= '0;
            acc      <= '0;
            quo      <= '0;
            mag      <= '0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            acc <= acc_n;
            quo <= quo_n;
            if (last) state <= IDLE;
        end else if (alu_inst_type == 3'd4) begin
            state    <= BUSY;
            cnt      <= '0;
            md_f3    <= f3;
            acc      <= '0;
            quo      <= s1 ? -alu_op1 : alu_op1;
            mag      <= s2 ? -alu_op2 : alu_op2;
            neg_p    <= s1 ^ s2;
            neg_r    <= s1;
            div_zero <= alu_op2 == 32'd0;
        end
    end
`else
    assign illegal   = alu_inst_type > 3'd3;
    assign ex_stall  = 1'b0;
    assign nxt_valid = alu_inst_type != 3'd0;
    assign nxt_data  = alu_res;
    assign nxt_ill   = illegal;
`endif

    // retirement register: all fields cleared unless an instruction retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_wb_addr <= '0;
            ex_wb_data <= '0;
            ex_pc      <= '0;
            ex_inst    <= '0;
            ex_illegal <= 1'b0;
        end else begin
            ex_valid   <= nxt_valid;
            ex_wb_en   <= nxt_valid && !nxt_ill && alu_rd_reg_en && alu_rd_reg_addr != 5'd0;
            ex_wb_addr <= nxt_valid ? alu_rd_reg_addr : 5'd0;
            ex_wb_data <= (nxt_valid && !nxt_ill) ? nxt_data : 32'd0;
            ex_pc      <= nxt_valid ? alu_pc : 32'd0;
            ex_inst    <= nxt_valid ? alu_inst : 32'd0;
            ex_illegal <= nxt_valid && nxt_ill;
        end
    end
endmodule

// File: tb/tb_ex_alu.sv
// tb_ex_alu: randomized and directed checks of ex_alu against a behavioural reference model.
module tb_ex_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_op1 = '0, alu_op2 = '0, alu_pc = '0, alu_inst = '0;
    logic        alu_rd_reg_en = 1'b0;
    logic [4:0]  alu_rd_reg_addr = '0;
    logic [2:0]  alu_inst_type = '0;
    logic        alu_or_flag = 1'b0;
    logic        ex_stall, ex_valid, ex_wb_en, ex_illegal;
    logic [4:0]  ex_wb_addr;
    logic [31:0] ex_wb_data, ex_pc, ex_inst;
    logic [103:0] act;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ex_alu dut (
        .clk(clk), .rst_n(rst_n),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_rd_reg_en(alu_rd_reg_en), .alu_rd_reg_addr(alu_rd_reg_addr),
        .alu_pc(alu_pc), .alu_inst(alu_inst),
        .alu_inst_type(alu_inst_type), .alu_or_flag(alu_or_flag),
        .ex_stall(ex_stall), .ex_valid(ex_valid),
        .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr), .ex_wb_data(ex_wb_data),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_illegal(ex_illegal)
    );

    assign act = {ex_valid, ex_wb_en, ex_wb_addr, ex_wb_data, ex_pc, ex_inst, ex_illegal};

    function automatic bit is_illegal(input logic [2:0] t);
`ifdef EX_MULDIV_EN
        return t > 3'd4;
`else
        return t > 3'd3;
`endif
    endfunction

    // architectural result of one instruction, from plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] t, input logic [31:0] a, b, pc, inst, input logic orf);
        logic [2:0] f;
        logic [31:0] sra;
        logic [63:0] p;
        logic signed [31:0] sq, sr;
        longint sa, sb;
        f   = inst[14:12];
        sra = $signed(a) >>> b[4:0];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (t == 3'd2) return b;
        if (t == 3'd3) return pc + 32'd4;
`ifdef EX_MULDIV_EN
        if (t == 3'd4) begin
            case (f)
                3'd0: begin p = sa * sb; return p[31:0]; end
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
                3'd4, 3'd6: begin
                    if (b == 32'd0) return (f == 3'd4) ? 32'hFFFFFFFF : a;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return (f == 3'd4) ? 32'h80000000 : 32'd0;
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    return (f == 3'd4) ? sq : sr;
                end
                default: begin
                    if (b == 32'd0) return (f == 3'd5) ? 32'hFFFFFFFF : a;
                    return (f == 3'd5) ? a / b : a % b;
                end
            endcase
        end
`endif
        if (t != 3'd1) return 32'd0;
        if (orf) return a | b;
        case (f)
            3'd0: return (inst[30] && inst[5]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return inst[30] ? sra : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [103:0] exp_vec(input logic [2:0] t, input logic [31:0] a, b, pc, inst,
                                             input logic en, input logic [4:0] rd, input logic orf);
        logic ill;
        ill = is_illegal(t);
        return {1'b1, en && rd != 5'd0 && !ill, rd, ill ? 32'd0 : model(t, a, b, pc, inst, orf), pc, inst, ill};
    endfunction

    task automatic drive(input logic [2:0] t, input logic [31:0] a, b, pc, inst,
                         input logic en, input logic [4:0] rd, input logic orf);
        alu_inst_type = t;
        alu_op1 = a;
        alu_op2 = b;
        alu_pc = pc;
        alu_inst = inst;
        alu_rd_reg_en = en;
        alu_rd_reg_addr = rd;
        alu_or_flag = orf;
    endtask

    task automatic test_reset;
        drive(3'd4, 32'd6, 32'd7, 32'h100, 32'h020003B3, 1'b1, 5'd7, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({ex_stall, act} !== 105'd0) $display("FAIL reset_state: got %h want 0", {ex_stall, act});
        else passed++;
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [2:0]  ts[8]  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
        logic [31:0] as[8]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000, 32'h12340000, 32'd1, 32'd2};
        logic [31:0] bs[8]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd4, 32'd4, 32'd4, 32'h00005678, 32'hABCD0000, 32'd3};
        logic [31:0] pcs[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h40, 32'hFFFFFFFC};
        logic [31:0] is[8]  = '{32'h000001B3, 32'h400001B3, 32'h40005233, 32'h00005233, 32'h40000293, 32'h40000333,
                                32'hABCD0437, 32'h000000EF};
        logic        os[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0]  rs[8]  = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd5, 5'd6, 5'd8, 5'd1};
        logic [31:0] xs[8]  = '{32'd2, 32'd8, 32'hF8000000, 32'h08000000, 32'h80000004, 32'h12345678,
                                32'hABCD0000, 32'd0};
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if ({ex_valid, ex_wb_en, ex_wb_addr, ex_wb_data} !== {2'b11, rs[i-1], xs[i-1]})
                    $display("FAIL directed_%0d: got v=%b we=%b rd=%0d data=%h want v=1 we=1 rd=%0d data=%h",
                             i - 1, ex_valid, ex_wb_en, ex_wb_addr, ex_wb_data, rs[i-1], xs[i-1]);
                else passed++;
            end
            if (i < 8) drive(ts[i], as[i], bs[i], pcs[i], is[i], 1'b1, rs[i], os[i]);
        end
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_random;
        logic [103:0] e;
        logic [2:0] t, pt;
        logic [31:0] a, b, pc, inst;
        logic en, orf;
        logic [4:0] rd;
        pt = 3'd0;
        e = '0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (pt == 3'd0) begin
                    if (ex_valid !== 1'b0) $display("FAIL random_bubble_%0d: got valid=%b want 0", i - 1, ex_valid);
                    else passed++;
                end else if (act !== e) $display("FAIL random_op_%0d type=%0d: got %h want %h", i - 1, pt, act, e);
                else passed++;
            end
            if (i < 300) begin
                t = 3'($urandom_range(0, 7));
`ifdef EX_MULDIV_EN
                if (t == 3'd4) t = 3'd1;
`endif
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                pc = $urandom;
                inst = $urandom;
                en = 1'($urandom_range(0, 1));
                rd = 5'($urandom_range(0, 31));
                orf = $urandom_range(0, 3) == 0;
                drive(t, a, b, pc, inst, en, rd, orf);
                e = exp_vec(t, a, b, pc, inst, en, rd, orf);
                pt = t;
                #1;
                total++;
                if (ex_stall !== 1'b0) $display("FAIL random_stall_%0d: got %b want 0", i, ex_stall);
                else passed++;
            end
        end
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_x0;
        @(negedge clk);
        drive(3'd1, 32'd5, 32'hFFFFFFFD, 32'h200, 32'h00000033, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        total++;
        if ({ex_valid, ex_wb_en, ex_wb_data} !== {2'b10, 32'd2})
            $display("FAIL rd_x0: got v=%b we=%b data=%h want v=1 we=0 data=2", ex_valid, ex_wb_en, ex_wb_data);
        else passed++;
`ifndef EX_MULDIV_EN
        drive(3'd4, 32'd6, 32'd7, 32'h204, 32'h020383B3, 1'b1, 5'd7, 1'b0);
        #1;
        total++;
        if (ex_stall !== 1'b0) $display("FAIL mul_disabled_stall: got %b want 0", ex_stall);
        else passed++;
        @(negedge clk);
        total++;
        if ({ex_stall, ex_valid, ex_illegal, ex_wb_en, ex_wb_data} !== {4'b0110, 32'd0})
            $display("FAIL mul_disabled_illegal: got s=%b v=%b ill=%b we=%b data=%h want s=0 v=1 ill=1 we=0 data=0",
                     ex_stall, ex_valid, ex_illegal, ex_wb_en, ex_wb_data);
        else passed++;
`endif
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

`ifdef EX_MULDIV_EN
    task automatic test_muldiv;
        logic [2:0]  fs[9] = '{3'd1, 3'd0, 3'd4, 3'd6, 3'd4, 3'd7, 3'd5, 3'd3, 3'd2};
        logic [31:0] as[9] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'h80000000, 32'h80000000, 32'd7, 32'd100,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[9] = '{32'd3, 32'd3, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd7, 32'hFFFFFFFF, 32'd2};
        logic [31:0] xs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd7, 32'd14,
                               32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [2:0] f;
        logic [31:0] a, b, pc, inst, x;
        logic [4:0] rd;
        logic [103:0] e;
        int stalls, badv;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            f = (i < 9) ? fs[i] : 3'($urandom_range(0, 7));
            a = (i < 9) ? as[i] : $urandom;
            b = (i < 9) ? bs[i] : ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rd = 5'($urandom_range(0, 31));
            pc = $urandom;
            inst = {7'b0000001, 5'($urandom), 5'($urandom), f, rd, 7'b0110011};
            x = (i < 9) ? xs[i] : model(3'd4, a, b, pc, inst, 1'b0);
            e = {1'b1, rd != 5'd0, rd, x, pc, inst, 1'b0};
            drive(3'd4, a, b, pc, inst, 1'b1, rd, 1'b0);
            #1;
            stalls = 0;
            badv = 0;
            while (ex_stall && stalls < 40) begin
                stalls++;
                if (ex_valid) badv++;
                @(negedge clk);
                #1;
            end
            if (ex_valid) badv++;
            total++;
            if (stalls != 32) $display("FAIL muldiv_%0d_stall_cycles: got %0d want 32", i, stalls);
            else passed++;
            total++;
            if (badv != 0) $display("FAIL muldiv_%0d_valid_while_busy: got %0d want 0", i, badv);
            else passed++;
            @(negedge clk);
            total++;
            if (act !== e) $display("FAIL muldiv_%0d f3=%0d a=%h b=%h: got %h want %h", i, f, a, b, act, e);
            else passed++;
        end
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask
`endif

    task automatic test_reset_busy;
        int seen;
        @(negedge clk);
        drive(3'd4, 32'd1000, 32'd7, 32'h300, 32'h0272D4B3, 1'b1, 5'd9, 1'b0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ex_stall, act} !== 105'd0) $display("FAIL reset_busy_clear: got %h want 0", {ex_stall, act});
        else passed++;
        @(negedge clk);
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ex_valid || ex_stall) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL reset_busy_no_retire: got %0d active cycles want 0", seen);
        else passed++;
        drive(3'd1, 32'd5, 32'hFFFFFFFD, 32'h400, 32'h000001B3, 1'b1, 5'd3, 1'b0);
        @(negedge clk);
        total++;
        if ({ex_valid, ex_wb_en, ex_wb_addr, ex_wb_data, ex_pc} !== {2'b11, 5'd3, 32'd2, 32'h400})
            $display("FAIL reset_busy_add_after: got v=%b we=%b rd=%0d data=%h pc=%h want v=1 we=1 rd=3 data=2 pc=400",
                     ex_valid, ex_wb_en, ex_wb_addr, ex_wb_data, ex_pc);
        else passed++;
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_x0;
`ifdef EX_MULDIV_EN
        test_muldiv;
`endif
        test_reset_busy;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
